// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width; one spare bit so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One shift / trial-subtract / restore step of an unsigned restoring divider.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_r_next,
    output logic [WIDTH-1:0] o_q_next
);

    logic [WIDTH:0] w_s;
    logic [WIDTH:0] w_t;
    logic           w_unused;

    // The working remainder always stays below the divisor, so its top bit is never needed.
    assign w_unused = i_r[WIDTH];

    assign w_s = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_t = w_s - {1'b0, i_divisor};

    always_comb begin
        o_r_next = w_t;
        o_q_next = {i_q[WIDTH-2:0], 1'b1};
        if (w_t[WIDTH]) begin
            o_r_next = w_s;
            o_q_next = {i_q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider: one restoring step per clock behind a start/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       r_state;
    logic [WIDTH:0]   r_work_r;
    logic [WIDTH-1:0] r_work_q;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;
    logic             r_done;

    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_accept;
    logic             w_unused;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r       (r_work_r),
        .i_q       (r_work_q),
        .i_divisor (r_div),
        .o_r_next  (w_r_next),
        .o_q_next  (w_q_next)
    );

    assign w_unused = w_r_next[WIDTH];
    assign w_accept = start && (r_state != RUN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_work_r    <= '0;
            r_work_q    <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    r_work_r <= w_r_next;
                    r_work_q <= w_q_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; the unused encoding falls back to IDLE.
                    if (w_accept) begin
                        if (divisor != '0) begin
                            r_work_r <= '0;
                            r_work_q <= dividend;
                            r_div    <= divisor;
                            r_cnt    <= '0;
                            r_state  <= RUN;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: transaction-level model plus directed and random operations.
module tb_seq_divider;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted op finishes WIDTH edges later with a/b and a%b.
    int m_left = 0;
    int m_pq = 0;
    int m_pr = 0;
    int m_q = 0;
    int m_r = 0;
    int m_z = 0;
    int m_done = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left = 0;
            m_q = 0;
            m_r = 0;
            m_z = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_q = m_pq;
                    m_r = m_pr;
                    m_z = 0;
                    m_done = 1;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_q = MAXV;
                    m_r = int'(dividend);
                    m_z = 1;
                    m_done = 1;
                end else begin
                    m_pq = int'(dividend) / int'(divisor);
                    m_pr = int'(dividend) % int'(divisor);
                    m_left = WIDTH;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
        chk("done", int'(done), m_done);
        chk("quotient", int'(quotient), m_q);
        chk("remainder", int'(remainder), m_r);
        chk("div_by_zero", int'(div_by_zero), m_z);
        if (done) done_cnt++;
    end

    // Called at a negedge with the DUT idle or in DONE. lat counts edges from the accepting
    // edge through the edge that raised done, inclusive (WIDTH+1 normally, 1 for divide by 0).
    // mode: 0 quiet, 1 random start/operand noise while busy, 2 start 2/1 on RUN cycle 2.
    task automatic run_op(input int a, input int b, input int mode,
                          output int q, output int r, output int z,
                          output int lat, output int bcnt);
        start = 1'b1;
        dividend = WIDTH'(a);
        divisor = WIDTH'(b);
        lat = 0;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            case (mode)
                1: begin
                    start = 1'($urandom_range(0, 1));
                    dividend = WIDTH'($urandom);
                    divisor = WIDTH'($urandom);
                end
                2: begin
                    start = (k == 2);
                    if (k == 2) begin
                        dividend = WIDTH'(2);
                        divisor = WIDTH'(1);
                    end
                end
                default: start = 1'b0;
            endcase
        end
        start = 1'b0;
        if (lat == 0) chk("done_timeout", 0, 1);
        q = int'(quotient);
        r = int'(remainder);
        z = int'(div_by_zero);
    endtask

    int q, r, z, lat, bcnt, dc0;
    int pairs[256];

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q", int'(quotient), 0);
        chk("reset_r", int'(remainder), 0);
        chk("reset_z", int'(div_by_zero), 0);
        resetn = 1'b1;
        @(negedge clk);

        // 13/3
        run_op(13, 3, 0, q, r, z, lat, bcnt);
        chk("13/3 q", q, 4);
        chk("13/3 r", r, 1);
        chk("13/3 z", z, 0);
        chk("13/3 lat", lat, WIDTH + 1);
        chk("13/3 busy_cycles", bcnt, WIDTH);
        repeat (2) @(negedge clk);

        // 15/1 then 7/9 started while the first is in DONE
        run_op(15, 1, 0, q, r, z, lat, bcnt);
        chk("15/1 q", q, 15);
        chk("15/1 r", r, 0);
        run_op(7, 9, 0, q, r, z, lat, bcnt);
        chk("7/9 q", q, 0);
        chk("7/9 r", r, 7);
        chk("7/9 lat", lat, WIDTH + 1);
        repeat (2) @(negedge clk);

        // 9/0
        run_op(9, 0, 0, q, r, z, lat, bcnt);
        chk("9/0 q", q, 15);
        chk("9/0 r", r, 9);
        chk("9/0 z", z, 1);
        chk("9/0 lat", lat, 1);
        chk("9/0 busy_cycles", bcnt, 0);
        repeat (2) @(negedge clk);

        // 13/3 with an ignored start of 2/1 during RUN
        dc0 = done_cnt;
        run_op(13, 3, 2, q, r, z, lat, bcnt);
        repeat (3) @(negedge clk);
        chk("ignored_start q", q, 4);
        chk("ignored_start r", r, 1);
        chk("ignored_start done_pulses", done_cnt - dc0, 1);

        // 14/5 abandoned by asynchronous reset on RUN cycle 2
        start = 1'b1;
        dividend = WIDTH'(14);
        divisor = WIDTH'(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dc0 = done_cnt;
        #2 resetn = 1'b0;
        #1;
        chk("async_reset busy", int'(busy), 0);
        chk("async_reset q", int'(quotient), 0);
        chk("async_reset r", int'(remainder), 0);
        chk("async_reset z", int'(div_by_zero), 0);
        repeat (6) @(negedge clk);
        chk("async_reset no_done", done_cnt - dc0, 0);
        resetn = 1'b1;
        @(negedge clk);
        run_op(14, 5, 0, q, r, z, lat, bcnt);
        chk("14/5 q", q, 2);
        chk("14/5 r", r, 4);

        // All 256 pairs in shuffled order, with random gaps and noise while busy
        for (int i = 0; i < 256; i++) pairs[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            int a, b;
            a = pairs[i] >> WIDTH;
            b = pairs[i] & MAXV;
            run_op(a, b, 1, q, r, z, lat, bcnt);
            if (b != 0) begin
                chk("sweep invariant", q * b + r, a);
                chk("sweep r_lt_b", (r < b) ? 1 : 0, 1);
                chk("sweep lat", lat, WIDTH + 1);
            end else begin
                chk("sweep div0 q", q, MAXV);
                chk("sweep div0 r", r, a);
                chk("sweep div0 lat", lat, 1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
